// File: rtl/wb_write_sequencer_pkg.sv
// Shared pipeline definitions for the write-back stage: widths, source selects
// and the sequencer state encoding.
package wb_write_sequencer_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } wb_state_e;

   // First-write data: clear wins over the source select.
   function automatic logic [DATA_W-1:0] first_write_data(
      input logic              clr,
      input logic              wb_sel,
      input logic [DATA_W-1:0] alu_result,
      input logic [DATA_W-1:0] mem_data
   );
      if (clr)
         return '0;
      else if (wb_sel == WB_SEL_MEM)
         return mem_data;
      else
         return alu_result;
   endfunction

endpackage

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: MEM/WB pipeline register, result select, and the
// single register-file write port with two-cycle serialization of dual writes.
//
// state  | meaning
// IDLE   | no instruction held, write port quiet
// FIRST  | first (or only) write of the held instruction
// SECOND | second write of a dual-destination instruction
module wb_write_sequencer
   import wb_write_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_wb_sel,
   input  logic              in_clr,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [ADDR_W-1:0] in_dst1,
   input  logic              in_dual,
   input  logic [ADDR_W-1:0] in_dst2,
   input  logic [DATA_W-1:0] in_data2,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [15:0]       retired
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_FIRST  = FIRST;
   localparam logic [1:0] ST_SECOND = SECOND;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              wb_en_q;
   logic              dual_q;
   logic [ADDR_W-1:0] dst1_q;
   logic [ADDR_W-1:0] dst2_q;
   logic [DATA_W-1:0] data1_q;
   logic [DATA_W-1:0] data2_q;
   logic              accept;

   // Register-only ready so the memory stage never sees a loop through in_valid.
   assign in_ready = !(state_q == ST_FIRST && dual_q);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:   state_d = accept ? ST_FIRST : ST_IDLE;
         ST_FIRST:  begin
            if (dual_q)
               state_d = ST_SECOND;
            else
               state_d = accept ? ST_FIRST : ST_IDLE;
         end
         ST_SECOND: state_d = accept ? ST_FIRST : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wb_en_q <= 1'b0;
         dual_q  <= 1'b0;
         dst1_q  <= '0;
         dst2_q  <= '0;
         data1_q <= '0;
         data2_q <= '0;
         retired <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wb_en_q <= in_wb_en;
            dual_q  <= in_dual && in_wb_en;
            dst1_q  <= in_dst1;
            dst2_q  <= in_dst2;
            data1_q <= first_write_data(in_clr, in_wb_sel, in_alu_result, in_mem_data);
            data2_q <= in_data2;
            retired <= retired + 16'd1;
         end
      end
   end

   always_comb begin
      rf_write_enable = 1'b0;
      rf_write_addr   = '0;
      rf_write_data   = '0;
      case (state_q)
         ST_FIRST: begin
            if (wb_en_q) begin
               rf_write_enable = 1'b1;
               rf_write_addr   = dst1_q;
               rf_write_data   = data1_q;
            end
         end
         ST_SECOND: begin
            rf_write_enable = 1'b1;
            rf_write_addr   = dst2_q;
            rf_write_data   = data2_q;
         end
         default: ;
      endcase
   end

   assign fwd_valid = rf_write_enable;
   assign fwd_addr  = rf_write_addr;
   assign fwd_data  = rf_write_data;

endmodule
